// File: rtl/mips_avalon_pkg.sv
`default_nettype none
// ============================================================================
// mips_avalon_pkg : shared types and constants for the CPU-side Avalon master
// Revision: 1.0
// ============================================================================
package mips_avalon_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUS_I = 2'd1,
        BUS_D = 2'd2,
        RESP  = 2'd3
    } state_e;

    typedef enum logic {
        CH_INSTR = 1'b0,
        CH_DATA  = 1'b1
    } channel_e;

    localparam logic [3:0]  BE_ALL        = 4'hF;
    localparam logic [31:0] TIMEOUT_RDATA = 32'h0;
    localparam int          WDOG_W        = 16;

endpackage : mips_avalon_pkg
`default_nettype wire

// File: rtl/mips_avalon_master.sv
`default_nettype none
// ============================================================================
// mips_avalon_master : arbitrates instruction-fetch and data requests onto a
//                      single Avalon-MM master port, with optional stall watchdog
// Revision: 1.0
// ============================================================================
module mips_avalon_master
    import mips_avalon_pkg::*;
#(
    parameter int unsigned TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic        d_ack,
    output logic [31:0] d_rdata,

    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    output logic [3:0]  avm_byteenable,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,

    output logic        timeout_err
);

    state_e             state_q, state_d;
    channel_e           last_grant_q, last_grant_d;
    channel_e           rsp_ch_q, rsp_ch_d;

    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [3:0]         be_q, be_d;
    logic               read_q, read_d;
    logic               write_q, write_d;

    logic [WDOG_W-1:0]  wdog_q, wdog_d;
    logic [WDOG_W-1:0]  wdog_inc;
    logic               wdog_fire;

    logic [31:0]        rsp_data_q, rsp_data_d;
    logic               rsp_load_q, rsp_load_d;

    logic               i_ack_q, i_ack_d;
    logic               d_ack_q, d_ack_d;
    logic [31:0]        i_rdata_q, i_rdata_d;
    logic [31:0]        d_rdata_q, d_rdata_d;
    logic               timeout_err_q, timeout_err_d;

    logic               grant_data;
    logic               unused_addr_lsbs;

    // The bus is word aligned; byte offsets are the CPU's concern.
    assign unused_addr_lsbs = ^{i_addr[1:0], d_addr[1:0]};

    // Data wins when alone, or on contention when instruction was served last.
    assign grant_data = d_req && (!i_req || (last_grant_q == CH_INSTR));

    assign wdog_inc  = (wdog_q == {WDOG_W{1'b1}}) ? wdog_q : wdog_q + 1'b1;
    assign wdog_fire = (TIMEOUT != 32'd0) && ({{(32-WDOG_W){1'b0}}, wdog_inc} >= TIMEOUT);

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        rsp_ch_d      = rsp_ch_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        be_d          = be_q;
        read_d        = read_q;
        write_d       = write_q;
        wdog_d        = wdog_q;
        rsp_data_d    = rsp_data_q;
        rsp_load_d    = rsp_load_q;
        i_ack_d       = 1'b0;
        d_ack_d       = 1'b0;
        i_rdata_d     = i_rdata_q;
        d_rdata_d     = d_rdata_q;
        timeout_err_d = timeout_err_q;

        case (state_q)
            IDLE: begin
                if (grant_data) begin
                    rsp_ch_d = CH_DATA;
                    if (d_we && (d_be == 4'h0)) begin
                        // Store touching no bytes: acknowledge without a bus cycle.
                        rsp_load_d = 1'b0;
                        state_d    = RESP;
                    end else begin
                        addr_d  = {d_addr[31:2], 2'b00};
                        wdata_d = d_we ? d_wdata : 32'h0;
                        be_d    = d_be;
                        read_d  = !d_we;
                        write_d = d_we;
                        wdog_d  = '0;
                        state_d = BUS_D;
                    end
                end else if (i_req) begin
                    rsp_ch_d = CH_INSTR;
                    addr_d   = {i_addr[31:2], 2'b00};
                    wdata_d  = 32'h0;
                    be_d     = BE_ALL;
                    read_d   = 1'b1;
                    write_d  = 1'b0;
                    wdog_d   = '0;
                    state_d  = BUS_I;
                end
            end

            BUS_I, BUS_D: begin
                if (!avm_waitrequest) begin
                    read_d     = 1'b0;
                    write_d    = 1'b0;
                    rsp_data_d = avm_readdata;
                    rsp_load_d = read_q;
                    state_d    = RESP;
                end else begin
                    wdog_d = wdog_inc;
                    if (wdog_fire) begin
                        read_d        = 1'b0;
                        write_d       = 1'b0;
                        rsp_data_d    = TIMEOUT_RDATA;
                        rsp_load_d    = 1'b1;
                        timeout_err_d = 1'b1;
                        state_d       = RESP;
                    end
                end
            end

            RESP: begin
                state_d      = IDLE;
                last_grant_d = rsp_ch_q;
                if (rsp_ch_q == CH_INSTR) begin
                    i_ack_d   = 1'b1;
                    i_rdata_d = rsp_data_q;
                end else begin
                    d_ack_d = 1'b1;
                    if (rsp_load_q) begin
                        d_rdata_d = rsp_data_q;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            last_grant_q  <= CH_INSTR;
            rsp_ch_q      <= CH_INSTR;
            addr_q        <= 32'h0;
            wdata_q       <= 32'h0;
            be_q          <= 4'h0;
            read_q        <= 1'b0;
            write_q       <= 1'b0;
            wdog_q        <= '0;
            rsp_data_q    <= 32'h0;
            rsp_load_q    <= 1'b0;
            i_ack_q       <= 1'b0;
            d_ack_q       <= 1'b0;
            i_rdata_q     <= 32'h0;
            d_rdata_q     <= 32'h0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            rsp_ch_q      <= rsp_ch_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            be_q          <= be_d;
            read_q        <= read_d;
            write_q       <= write_d;
            wdog_q        <= wdog_d;
            rsp_data_q    <= rsp_data_d;
            rsp_load_q    <= rsp_load_d;
            i_ack_q       <= i_ack_d;
            d_ack_q       <= d_ack_d;
            i_rdata_q     <= i_rdata_d;
            d_rdata_q     <= d_rdata_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign avm_address    = addr_q;
    assign avm_read       = read_q;
    assign avm_write      = write_q;
    assign avm_writedata  = wdata_q;
    assign avm_byteenable = be_q;
    assign i_ack          = i_ack_q;
    assign i_rdata        = i_rdata_q;
    assign d_ack          = d_ack_q;
    assign d_rdata        = d_rdata_q;
    assign timeout_err    = timeout_err_q;

endmodule : mips_avalon_master
`default_nettype wire

// File: tb/tb_mips_avalon_master.sv
`default_nettype none
// ============================================================================
// tb_mips_avalon_master : directed bench with a small Avalon slave model
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_mips_avalon_master;

    localparam int unsigned TIMEOUT    = 4;
    localparam int unsigned READ_DELAY = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mips_avalon_master #(.TIMEOUT(TIMEOUT)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_req           (i_req),
        .i_addr          (i_addr),
        .i_ack           (i_ack),
        .i_rdata         (i_rdata),
        .d_req           (d_req),
        .d_we            (d_we),
        .d_addr          (d_addr),
        .d_wdata         (d_wdata),
        .d_be            (d_be),
        .d_ack           (d_ack),
        .d_rdata         (d_rdata),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_byteenable  (avm_byteenable),
        .avm_waitrequest (avm_waitrequest),
        .avm_readdata    (avm_readdata),
        .timeout_err     (timeout_err)
    );

    // Slave model: READ_DELAY stall cycles per access, 256-word RAM, word 0 holds the reset vector.
    logic [31:0] mem [0:255];
    int unsigned wcnt      = 0;
    bit          mem_ready = 1'b0;
    logic        stall_all = 1'b0;

    assign avm_waitrequest = stall_all || ((avm_read || avm_write) && (wcnt < READ_DELAY));
    assign avm_readdata    = mem[avm_address[9:2]];

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int k = 0; k < 256; k++) mem[k] <= 32'h0;
            mem[0]    <= 32'h24020005;
            mem_ready <= 1'b1;
        end else if (avm_write && !avm_waitrequest) begin
            for (int b = 0; b < 4; b++)
                if (avm_byteenable[b]) mem[avm_address[9:2]][8*b +: 8] <= avm_writedata[8*b +: 8];
        end
        if ((avm_read || avm_write) && avm_waitrequest) wcnt <= wcnt + 1;
        else                                            wcnt <= 0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_req = 1'b0; i_addr = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_be = 4'h0;
        tick(); tick(); tick();
        n_checks++; if ({i_ack, d_ack, avm_read, avm_write, timeout_err} !== 5'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 00000", {i_ack, d_ack, avm_read, avm_write, timeout_err});
        end
        n_checks++; if ({avm_address, avm_writedata, avm_byteenable} !== 68'h0) begin
            n_fail++; $display("FAIL reset_bus: addr %h wdata %h be %h expected zeros", avm_address, avm_writedata, avm_byteenable);
        end
        n_checks++; if ({i_rdata, d_rdata} !== 64'h0) begin
            n_fail++; $display("FAIL reset_rdata: i %h d %h expected zeros", i_rdata, d_rdata);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fetch();
        int edges; int rd_cyc; bit unstable;
        rd_cyc = 0; unstable = 1'b0;
        i_req = 1'b1; i_addr = 32'hBFC00000;
        tick(); edges = 1;
        n_checks++; if (avm_read !== 1'b1 || avm_address !== 32'hBFC00000 || avm_byteenable !== 4'hF) begin
            n_fail++; $display("FAIL fetch_issue: rd %b addr %h be %h expected 1 bfc00000 f", avm_read, avm_address, avm_byteenable);
        end
        i_addr = 32'h12345678;
        while (!i_ack && edges < 30) begin
            if (avm_read) rd_cyc++;
            if (avm_read && (avm_address !== 32'hBFC00000 || avm_byteenable !== 4'hF)) unstable = 1'b1;
            tick(); edges++;
        end
        n_checks++; if (edges !== 5) begin
            n_fail++; $display("FAIL fetch_latency: got %0d edges expected 5", edges);
        end
        n_checks++; if (rd_cyc !== 3 || unstable) begin
            n_fail++; $display("FAIL fetch_read_hold: got %0d read cycles unstable=%b expected 3 and 0", rd_cyc, unstable);
        end
        n_checks++; if (i_rdata !== 32'h24020005) begin
            n_fail++; $display("FAIL fetch_rdata: got %h expected 24020005", i_rdata);
        end
        i_req = 1'b0;
        tick();
        n_checks++; if (i_ack !== 1'b0 || avm_read !== 1'b0) begin
            n_fail++; $display("FAIL fetch_ack_pulse: ack %b rd %b expected 0 0", i_ack, avm_read);
        end
    endtask

    task automatic test_store_load();
        int edges;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'hAABBCCDD; d_be = 4'b0011;
        tick(); edges = 1;
        n_checks++; if (avm_write !== 1'b1 || avm_read !== 1'b0 || avm_byteenable !== 4'b0011 ||
                        avm_writedata !== 32'hAABBCCDD || avm_address !== 32'h10) begin
            n_fail++; $display("FAIL store_issue: wr %b rd %b be %b wd %h addr %h expected 1 0 0011 aabbccdd 10",
                               avm_write, avm_read, avm_byteenable, avm_writedata, avm_address);
        end
        while (!d_ack && edges < 30) begin tick(); edges++; end
        n_checks++; if (d_ack !== 1'b1 || edges !== 5) begin
            n_fail++; $display("FAIL store_ack: ack %b after %0d edges expected 1 after 5", d_ack, edges);
        end
        d_req = 1'b0;
        tick();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h12; d_be = 4'hF; d_wdata = 32'h0;
        tick(); edges = 1;
        n_checks++; if (avm_read !== 1'b1 || avm_write !== 1'b0 || avm_address !== 32'h10) begin
            n_fail++; $display("FAIL load_issue: rd %b wr %b addr %h expected 1 0 10", avm_read, avm_write, avm_address);
        end
        while (!d_ack && edges < 30) begin tick(); edges++; end
        n_checks++; if (d_ack !== 1'b1 || d_rdata !== 32'h0000CCDD) begin
            n_fail++; $display("FAIL load_rdata: ack %b data %h expected 1 0000ccdd", d_ack, d_rdata);
        end
        d_req = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [2:0] seq; int nack; int cyc; bit overlap;
        seq = 3'b000; nack = 0; cyc = 0; overlap = 1'b0;
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        i_req = 1'b1; i_addr = 32'hBFC00000;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10; d_be = 4'hF;
        while (nack < 3 && cyc < 100) begin
            tick(); cyc++;
            if (i_ack && d_ack) overlap = 1'b1;
            if (d_ack)      begin seq[nack] = 1'b1; nack++; end
            else if (i_ack) begin seq[nack] = 1'b0; nack++; end
            if (nack == 3) begin i_req = 1'b0; d_req = 1'b0; end
        end
        n_checks++; if (nack !== 3 || seq !== 3'b101 || overlap) begin
            n_fail++; $display("FAIL b2b_order: got %0d acks seq %b overlap %b expected 3 acks seq 101 overlap 0", nack, seq, overlap);
        end
        n_checks++; if (d_rdata !== 32'h0000CCDD || i_rdata !== 32'h24020005) begin
            n_fail++; $display("FAIL b2b_rdata: d %h i %h expected 0000ccdd 24020005", d_rdata, i_rdata);
        end
        i_req = 1'b0; d_req = 1'b0;
        tick(); tick();
        n_checks++; if (i_ack !== 1'b0 || d_ack !== 1'b0 || avm_read !== 1'b0) begin
            n_fail++; $display("FAIL b2b_quiet: i_ack %b d_ack %b rd %b expected 0 0 0", i_ack, d_ack, avm_read);
        end
    endtask

    task automatic test_store_be0();
        int edges; bit saw_write;
        edges = 0; saw_write = 1'b0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hFFFFFFFF; d_be = 4'h0;
        while (!d_ack && edges < 20) begin
            tick(); edges++;
            if (avm_write) saw_write = 1'b1;
        end
        n_checks++; if (d_ack !== 1'b1 || edges !== 2) begin
            n_fail++; $display("FAIL be0_ack: ack %b after %0d edges expected 1 after 2", d_ack, edges);
        end
        d_req = 1'b0;
        tick();
        if (avm_write) saw_write = 1'b1;
        n_checks++; if (saw_write || mem[8] !== 32'h0) begin
            n_fail++; $display("FAIL be0_nowrite: write seen %b mem %h expected 0 00000000", saw_write, mem[8]);
        end
    endtask

    task automatic test_timeout();
        int edges; int rd_cyc;
        rd_cyc = 0;
        n_checks++; if (timeout_err !== 1'b0) begin
            n_fail++; $display("FAIL wdog_pre: got %b expected 0", timeout_err);
        end
        stall_all = 1'b1;
        i_req = 1'b1; i_addr = 32'hBFC00000;
        tick(); edges = 1;
        while (!i_ack && edges < 30) begin
            if (avm_read) rd_cyc++;
            tick(); edges++;
        end
        n_checks++; if (rd_cyc !== 4 || edges !== 6) begin
            n_fail++; $display("FAIL wdog_drop: got %0d read cycles, ack after %0d edges expected 4 and 6", rd_cyc, edges);
        end
        n_checks++; if (i_ack !== 1'b1 || i_rdata !== 32'h0 || timeout_err !== 1'b1) begin
            n_fail++; $display("FAIL wdog_ack: ack %b rdata %h err %b expected 1 00000000 1", i_ack, i_rdata, timeout_err);
        end
        i_req = 1'b0; stall_all = 1'b0;
        tick(); tick(); tick();
        n_checks++; if (timeout_err !== 1'b1 || avm_read !== 1'b0) begin
            n_fail++; $display("FAIL wdog_sticky: err %b rd %b expected 1 0", timeout_err, avm_read);
        end
    endtask

    task automatic test_reset_midbus();
        int edges; bit bad;
        bad = 1'b0;
        stall_all = 1'b1;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h30; d_wdata = 32'h12345678; d_be = 4'hF;
        tick();
        n_checks++; if (avm_write !== 1'b1) begin
            n_fail++; $display("FAIL midrst_issue: wr %b expected 1", avm_write);
        end
        tick();
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (avm_write !== 1'b0 || timeout_err !== 1'b0 || d_ack !== 1'b0) begin
            n_fail++; $display("FAIL midrst_async: wr %b err %b ack %b expected 0 0 0", avm_write, timeout_err, d_ack);
        end
        d_req = 1'b0; stall_all = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (d_ack || avm_write) bad = 1'b1;
        end
        n_checks++; if (bad || mem[12] !== 32'h0) begin
            n_fail++; $display("FAIL midrst_abandon: stray ack/write %b mem %h expected 0 00000000", bad, mem[12]);
        end
        i_req = 1'b1; i_addr = 32'hBFC00000;
        edges = 0;
        while (!i_ack && edges < 30) begin tick(); edges++; end
        n_checks++; if (i_ack !== 1'b1 || i_rdata !== 32'h24020005) begin
            n_fail++; $display("FAIL midrst_recover: ack %b rdata %h expected 1 24020005", i_ack, i_rdata);
        end
        i_req = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store_load();
        test_back_to_back();
        test_store_be0();
        test_timeout();
        test_reset_midbus();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded 200000 ns, expected completion earlier");
        $fatal(1, "bench did not finish");
    end

endmodule : tb_mips_avalon_master
`default_nettype wire
